// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct
// constants and the mux-select / ALU operation codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Opcodes that need the EX state after decode.
    function automatic logic op_goes_ex(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU operation decode from the latched opcode and the funct field; flags an
// undecodable funct for R-type instructions.
module alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       funct_ill_o
);

    always_comb begin
        alu_ctrl_o  = ALU_ADD;
        funct_ill_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_ill_o = 1'b1;
                endcase
            end
            OP_BEQ:  alu_ctrl_o = ALU_SUB;
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-state multi-cycle CPU controller (IF/ID/EX/MEM/WB) with a MEM wait counter.
// Define JAL_LINK_EN to make jal write PC+4 to r31; otherwise jal acts as j.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] WDSel,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUCtrl,
    output logic       Illegal
);

    localparam logic [3:0] WAIT_INIT = MEM_WAIT[3:0];

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_ctrl;
    logic       funct_ill;

    alu_dec u_alu_dec (
        .op_i       (op_q),
        .funct_i    (Funct),
        .alu_ctrl_o (alu_ctrl),
        .funct_ill_o(funct_ill)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IF;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                op_d = Op;
                if (op_goes_ex(Op)) begin
                    state_d = S_EX;
`ifdef JAL_LINK_EN
                end else if (Op == OP_JAL) begin
                    state_d = S_WB;
`endif
                end else begin
                    state_d = S_IF;
                end
            end
            S_EX: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                        cnt_d   = WAIT_INIT;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_IF;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Reset gates every output so nothing is asserted while rstn is low.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        WDSel    = WD_ALU;
        RegDst   = RD_RT;
        PCSrc    = PC_PLUS4;
        ALUCtrl  = 4'b0000;
        Illegal  = 1'b0;
        if (rstn) begin
            case (state_q)
                S_IF: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = PC_PLUS4;
                end
                S_ID: begin
                    case (Op)
                        OP_J: begin
                            PCWrite = 1'b1;
                            PCSrc   = PC_JUMP;
                        end
                        OP_JAL: begin
`ifndef JAL_LINK_EN
                            PCWrite = 1'b1;
                            PCSrc   = PC_JUMP;
`endif
                        end
                        default: Illegal = !op_goes_ex(Op);
                    endcase
                end
                S_EX: begin
                    ALUCtrl = alu_ctrl;
                    Illegal = funct_ill;
                    if (op_q == OP_BEQ && Zero) begin
                        PCWrite = 1'b1;
                        PCSrc   = PC_BRANCH;
                    end
                end
                S_MEM: begin
                    MemRead  = (op_q == OP_LW);
                    MemWrite = (op_q == OP_SW);
                end
                S_WB: begin
                    case (op_q)
                        OP_RTYPE: begin
                            RegWrite = !funct_ill;
                            RegDst   = RD_RD;
                        end
                        OP_ADDI: RegWrite = 1'b1;
                        OP_LW: begin
                            RegWrite = 1'b1;
                            WDSel    = WD_MEM;
                        end
`ifdef JAL_LINK_EN
                        OP_JAL: begin
                            RegWrite = 1'b1;
                            WDSel    = WD_PC4;
                            RegDst   = RD_R31;
                            PCWrite  = 1'b1;
                            PCSrc    = PC_JUMP;
                        end
`endif
                        default: RegWrite = 1'b0;
                    endcase
                end
                default: IRWrite = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl (MEM_WAIT=2), plus reset sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, Illegal;
    logic [1:0] WDSel, RegDst, PCSrc;
    logic [3:0] ALUCtrl;
    logic [15:0] outs;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.MEM_WAIT(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .Op      (Op),
        .Funct   (Funct),
        .Zero    (Zero),
        .PCWrite (PCWrite),
        .IRWrite (IRWrite),
        .RegWrite(RegWrite),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .WDSel   (WDSel),
        .RegDst  (RegDst),
        .PCSrc   (PCSrc),
        .ALUCtrl (ALUCtrl),
        .Illegal (Illegal)
    );

    always #5 clk = ~clk;

    assign outs = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
                   WDSel, RegDst, PCSrc, ALUCtrl, Illegal};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       scramble;
        int         cyc;
        int         rw;
        int         mr;
        int         mw;
        int         ill;
        int         pcbr;
        int         pcj;
        logic [1:0] wd;
        logic [1:0] rd;
        logic [3:0] alu;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input logic scr, input int cyc, input int rw,
                                input int mr, input int mw, input int ill, input int pcbr,
                                input int pcj, input logic [1:0] wd, input logic [1:0] rd,
                                input logic [3:0] alu);
        vec_t v;
        v.name = n; v.op = op; v.funct = fn; v.zero = z; v.scramble = scr;
        v.cyc = cyc; v.rw = rw; v.mr = mr; v.mw = mw; v.ill = ill;
        v.pcbr = pcbr; v.pcj = pcj; v.wd = wd; v.rd = rd; v.alu = alu;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one instruction starting just after a negedge in IF; returns just after the
    // negedge of the following IF.
    task automatic run_instr(input vec_t v);
        int cyc = 0, rw = 0, mr = 0, mw = 0, ill = 0, pcbr = 0, pcj = 0, wd11 = 0;
        logic [1:0] wd = 2'b00, rd = 2'b00;
        logic [3:0] alu = 4'b0000;
        Op = v.op; Funct = v.funct; Zero = v.zero;
        #1;
        while (1) begin
            rw   += int'(RegWrite);
            mr   += int'(MemRead);
            mw   += int'(MemWrite);
            ill  += int'(Illegal);
            pcbr += int'(PCWrite && PCSrc == 2'b01);
            pcj  += int'(PCWrite && PCSrc == 2'b10);
            wd11 += int'(WDSel == 2'b11);
            if (RegWrite) begin
                wd = WDSel;
                rd = RegDst;
            end
            if (cyc == 2) alu = ALUCtrl;
            if (cyc == 2 && v.scramble) Op = 6'b111111;
            cyc++;
            @(posedge clk);
            @(negedge clk);
            #1;
            if (IRWrite) break;
            if (cyc > 40) begin
                check({v.name, ".timeout"}, 32'd1, 32'd0);
                break;
            end
        end
        check({v.name, ".cyc"},  cyc,  v.cyc);
        check({v.name, ".rw"},   rw,   v.rw);
        check({v.name, ".mr"},   mr,   v.mr);
        check({v.name, ".mw"},   mw,   v.mw);
        check({v.name, ".ill"},  ill,  v.ill);
        check({v.name, ".pcbr"}, pcbr, v.pcbr);
        check({v.name, ".pcj"},  pcj,  v.pcj);
        check({v.name, ".wd"},   {30'd0, wd}, {30'd0, v.wd});
        check({v.name, ".rd"},   {30'd0, rd}, {30'd0, v.rd});
        check({v.name, ".alu"},  {28'd0, alu}, {28'd0, v.alu});
        check({v.name, ".wd11"}, wd11, 0);
    endtask

    initial begin
        //            name      op         funct      z     scr  cyc rw mr mw il br j  wd     rd     alu
        tbl[0]  = mk("add",    6'b000000, 6'b100000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0010);
        tbl[1]  = mk("sub",    6'b000000, 6'b100010, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0110);
        tbl[2]  = mk("and",    6'b000000, 6'b100100, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0000);
        tbl[3]  = mk("or",     6'b000000, 6'b100101, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0001);
        tbl[4]  = mk("slt",    6'b000000, 6'b101010, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0111);
        tbl[5]  = mk("badfn",  6'b000000, 6'b000000, 1'b0, 1'b0, 4, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0010);
        tbl[6]  = mk("addi",   6'b001000, 6'b000000, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0010);
        tbl[7]  = mk("lw",     6'b100011, 6'b000000, 1'b0, 1'b0, 7, 1, 3, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010);
        tbl[8]  = mk("sw",     6'b101011, 6'b000000, 1'b0, 1'b0, 6, 0, 0, 3, 0, 0, 0, 2'b00, 2'b00, 4'b0010);
        tbl[9]  = mk("beq_t",  6'b000100, 6'b000000, 1'b1, 1'b0, 3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0110);
        tbl[10] = mk("beq_nt", 6'b000100, 6'b000000, 1'b0, 1'b0, 3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0110);
        tbl[11] = mk("j",      6'b000010, 6'b000000, 1'b0, 1'b0, 2, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000);
`ifdef JAL_LINK_EN
        tbl[12] = mk("jal",    6'b000011, 6'b000000, 1'b0, 1'b0, 3, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 4'b0000);
`else
        tbl[12] = mk("jal",    6'b000011, 6'b000000, 1'b0, 1'b0, 2, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'b0000);
`endif
        tbl[13] = mk("badop",  6'b111111, 6'b000000, 1'b0, 1'b0, 2, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000);
        tbl[14] = mk("lw_scr", 6'b100011, 6'b000000, 1'b0, 1'b1, 7, 1, 3, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0010);

        // Reset held with a lw opcode on the bus.
        rstn = 1'b0; Op = 6'b100011; Funct = 6'b000000; Zero = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outs", {16'd0, outs}, 32'd0);
        rstn = 1'b1;
        #1;
        check("rst_if", {16'd0, outs}, 32'h0000_C000);

        for (int i = 0; i < 15; i++) run_instr(tbl[i]);

        // Reset pulsed while sw is in MEM.
        Op = 6'b101011; Funct = 6'b000000; Zero = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("sw_mem_mw", {31'd0, MemWrite}, 32'd1);
        rstn = 1'b0;
        #1;
        check("sw_abort", {16'd0, outs}, 32'd0);
        @(negedge clk);
        check("sw_rst_hold", {16'd0, outs}, 32'd0);
        rstn = 1'b1;
        #1;
        check("sw_post_if", {16'd0, outs}, 32'h0000_C000);
        run_instr(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
